// File: rtl/pcm_cfg_sequencer.sv
// PCM decoder control-word sequencer: applies a requested word on a symbol
// boundary, then holds the output FIFO in reset while decoder history refills.
//
// Ports:
//   clk, rs_n    clock / async active-low reset
//   symb_clk_en  one-clk symbol strobe from bit sync
//   cfg_wr       one-clk pulse, cfg_din holds a new requested word
//   cfg_din      requested control word
//   cfg_active   control word driving the decoder datapath
//   fifo_rs_out  decoder output FIFO reset (software bit0 or sequence flush)
//   data_valid   decoder output trusted
//   busy         sequencer not idle
//   done         one-clk pulse when a sequence completes into IDLE
//   timeout      sticky watchdog flag, cleared by a new request from IDLE
//   state_o      current state (IDLE=0, WAIT_SYM=1, APPLY=2, FLUSH=3)
module pcm_cfg_sequencer #(
    parameter int unsigned      CFG_W         = 13,
    parameter logic [CFG_W-1:0] RESET_CFG     = '0,
    parameter int unsigned      FLUSH_SYMBOLS = 16,
    parameter int unsigned      WATCHDOG_CLKS = 4096
) (
    input  logic             clk,
    input  logic             rs_n,
    input  logic             symb_clk_en,
    input  logic             cfg_wr,
    input  logic [CFG_W-1:0] cfg_din,
    output logic [CFG_W-1:0] cfg_active,
    output logic             fifo_rs_out,
    output logic             data_valid,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SYM = 2'd1,
        APPLY    = 2'd2,
        FLUSH    = 2'd3
    } state_e;

    localparam logic [15:0] WD_LAST  = 16'(WATCHDOG_CLKS - 1);
    localparam logic [7:0]  SYM_LAST = 8'(FLUSH_SYMBOLS - 1);

    state_e             state_q, state_d;
    logic [CFG_W-1:0]   cfg_active_q, cfg_active_d;
    logic [CFG_W-1:0]   pending_q, pending_d;
    logic [7:0]         sym_cnt_q, sym_cnt_d;
    logic [15:0]        wd_cnt_q, wd_cnt_d;
    logic               restart_q, restart_d;
    logic               timeout_q, timeout_d;
    logic               done_q, done_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               fifo_rs_q, fifo_rs_d;

    logic [15:0]        wd_inc;
    logic [7:0]         sym_inc;
    logic               wd_hit;
    logic               flush_exit;

    // Counters saturate rather than wrap.
    assign wd_inc  = (wd_cnt_q == 16'hFFFF) ? wd_cnt_q : wd_cnt_q + 16'd1;
    assign sym_inc = (sym_cnt_q == 8'hFF) ? sym_cnt_q : sym_cnt_q + 8'd1;
    assign wd_hit  = (wd_cnt_q == WD_LAST);

    always_comb begin
        state_d      = state_q;
        cfg_active_d = cfg_active_q;
        pending_d    = pending_q;
        sym_cnt_d    = sym_cnt_q;
        wd_cnt_d     = wd_cnt_q;
        restart_d    = restart_q;
        timeout_d    = timeout_q;
        done_d       = 1'b0;
        flush_exit   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cfg_wr) begin
                    pending_d = cfg_din;
                    timeout_d = 1'b0;
                    wd_cnt_d  = '0;
                    state_d   = WAIT_SYM;
                end
            end
            WAIT_SYM: begin
                // Newest word wins; still a single apply.
                if (cfg_wr) pending_d = cfg_din;
                if (symb_clk_en) begin
                    state_d = APPLY;
                end else if (wd_hit) begin
                    state_d   = APPLY;
                    timeout_d = 1'b1;
                end else begin
                    wd_cnt_d = wd_inc;
                end
            end
            APPLY: begin
                // Applies the pre-latch pending; a write here forces a rerun.
                cfg_active_d = pending_q;
                sym_cnt_d    = '0;
                wd_cnt_d     = '0;
                restart_d    = cfg_wr;
                if (cfg_wr) pending_d = cfg_din;
                state_d = FLUSH;
            end
            FLUSH: begin
                if (cfg_wr) begin
                    pending_d = cfg_din;
                    restart_d = 1'b1;
                end
                if (symb_clk_en) begin
                    sym_cnt_d  = sym_inc;
                    wd_cnt_d   = '0;
                    flush_exit = (sym_cnt_q == SYM_LAST);
                end else begin
                    wd_cnt_d = wd_inc;
                    if (wd_hit) begin
                        flush_exit = 1'b1;
                        timeout_d  = 1'b1;
                    end
                end
                if (flush_exit) begin
                    if (restart_q || cfg_wr) begin
                        state_d  = WAIT_SYM;
                        wd_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        valid_d   = (state_d == IDLE);
        busy_d    = (state_d != IDLE);
        fifo_rs_d = cfg_active_d[0] | (state_d == APPLY) | (state_d == FLUSH);
    end

    always_ff @(posedge clk or negedge rs_n) begin
        if (!rs_n) begin
            state_q      <= IDLE;
            cfg_active_q <= RESET_CFG;
            pending_q    <= RESET_CFG;
            sym_cnt_q    <= '0;
            wd_cnt_q     <= '0;
            restart_q    <= 1'b0;
            timeout_q    <= 1'b0;
            done_q       <= 1'b0;
            valid_q      <= 1'b1;
            busy_q       <= 1'b0;
            fifo_rs_q    <= RESET_CFG[0];
        end else begin
            state_q      <= state_d;
            cfg_active_q <= cfg_active_d;
            pending_q    <= pending_d;
            sym_cnt_q    <= sym_cnt_d;
            wd_cnt_q     <= wd_cnt_d;
            restart_q    <= restart_d;
            timeout_q    <= timeout_d;
            done_q       <= done_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            fifo_rs_q    <= fifo_rs_d;
        end
    end

    assign cfg_active  = cfg_active_q;
    assign fifo_rs_out = fifo_rs_q;
    assign data_valid  = valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign state_o     = state_q;

endmodule
